// File: rtl/pci_phy_pkg.sv
// pci_phy_pkg: constants and state encoding shared by the PCIe PHY lane blocks
package pci_phy_pkg;
  localparam int SYM_W = 8;
  localparam logic [SYM_W-1:0] COMMA = 8'hBC;
  typedef enum logic {SYNC, RUN} tx_state_t;
endpackage

// File: rtl/paralelo_serial.sv
// paralelo_serial: byte-to-serial lane transmitter with comma preamble and comma idle fill
module paralelo_serial #(
  parameter int SYNC_SYMBOLS = 4,
  parameter logic [7:0] COMMA = pci_phy_pkg::COMMA
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out,
  output logic       sym_start
);
  import pci_phy_pkg::*;
  tx_state_t        state;
  logic [3:0]       sync_cnt;
  logic [SYM_W-1:0] shreg, shreg_n, hold, sym;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic             boundary, xfer, load_hold, hold_full, hold_full_n;
  // next symbol selection: held byte only in RUN, otherwise a comma fills the slot
  always_comb begin
    boundary    = bit_cnt == 3'd7;
    xfer        = valid_in && ready_out;
    load_hold   = boundary && state == RUN && hold_full;
    sym         = load_hold ? hold : COMMA;
    shreg_n     = boundary ? sym : shreg << 1;
    bit_cnt_n   = boundary ? 3'd0 : bit_cnt + 3'd1;
    hold_full_n = xfer || (hold_full && !load_hold);
  end
  // shift register and serial outputs, MSB first, outputs track the next shreg state
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      bit_cnt   <= 3'd7;
      data_out  <= 1'b0;
      sym_start <= 1'b0;
    end else begin
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      data_out  <= shreg_n[SYM_W-1];
      sym_start <= bit_cnt_n == 3'd0;
    end
  end
  // preamble sequencer: count commas at each boundary, then run for good
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state      <= SYNC;
      sync_cnt   <= '0;
      active_out <= 1'b0;
    end else if (boundary) begin
      if (state == SYNC) begin
        sync_cnt <= sync_cnt + 4'd1;
        if (sync_cnt == 4'(SYNC_SYMBOLS - 1)) state <= RUN;
      end else active_out <= 1'b1;
    end
  end
  // 1-deep holding register; ready mirrors an empty hold, held low on the release cycle
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
      ready_out <= 1'b0;
    end else begin
      hold_full <= hold_full_n;
      ready_out <= !hold_full_n;
      if (xfer) hold <= data_in;
    end
  end
endmodule

// File: tb/tb_paralelo_serial.sv
// tb_paralelo_serial: scoreboard bench for the serial lane transmitter
module tb_paralelo_serial;
  logic       clk_32f, reset, valid_in, ready_out, data_out, active_out, sym_start;
  logic [7:0] data_in;
  int         checks = 0, failures = 0, cyc = 0, ndata = 0;
  logic [7:0] syms[$];
  logic [7:0] exp_q[$];

  paralelo_serial dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .active_out(active_out), .sym_start(sym_start)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] sym_at(input int k);
    return (k < syms.size()) ? {24'h0, syms[k]} : 32'hFFFF_FFFF;
  endfunction

  // receiver model: assemble symbols from sym_start, score non-comma bytes
  logic [7:0] sh;
  int         nb = 0;
  always @(negedge clk_32f) begin
    if (!reset) begin
      syms.delete();
      exp_q.delete();
      nb = 0;
    end else begin
      if (sym_start) begin
        sh = {7'h0, data_out};
        nb = 1;
      end else if (nb > 0 && nb < 8) begin
        sh = {sh[6:0], data_out};
        nb++;
      end
      if (nb == 8) begin
        nb = 0;
        syms.push_back(sh);
        if (sh != 8'hBC) begin
          ndata++;
          if (exp_q.size() == 0) chk("unexpected_byte", sh, 8'hBC);
          else chk("data_byte", sh, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_32f);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic rel();
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic send(input logic [7:0] b, input bit track, output int w);
    data_in = b;
    valid_in = 1'b1;
    w = 0;
    while (!ready_out && w < 40) begin
      tick();
      w++;
    end
    chk("send_ready", ready_out, 1);
    tick();
    valid_in = 1'b0;
    if (track) exp_q.push_back(b);
  endtask

  task automatic preamble_only(input string tag);
    int nr = 0, ns = 0, bad = 0, fa = 0, nc = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (ready_out) nr++;
      if (sym_start) begin
        ns++;
        if (i % 8 != 1) bad++;
      end
      if (active_out && fa == 0) fa = i;
    end
    tick();
    chk({tag, "_ready"}, nr, 64);
    chk({tag, "_starts"}, ns, 8);
    chk({tag, "_phase"}, bad, 0);
    chk({tag, "_active_at"}, fa, 33);
    chk({tag, "_nsyms"}, syms.size(), 8);
    foreach (syms[k]) if (syms[k] != 8'hBC) nc++;
    chk({tag, "_commas"}, nc, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int w, w2, w3, nd;
    reset = 1'b0;
    valid_in = 1'b0;
    data_in = 8'h00;
    repeat (3) tick();
    chk("rst_data", data_out, 0);
    chk("rst_ready", ready_out, 0);
    chk("rst_active", active_out, 0);
    chk("rst_symstart", sym_start, 0);
    rel();
    chk("release_ready_gated", ready_out, 0);
    preamble_only("idle");

    reset = 1'b0;
    repeat (2) tick();
    rel();
    run_to(2);
    send(8'hA5, 1'b1, w);
    chk("a5_ready_lo", ready_out, 0);
    run_to(32);
    chk("a5_ready_held", ready_out, 0);
    run_to(33);
    chk("a5_ready_back", ready_out, 1);
    chk("a5_active", active_out, 1);
    run_to(49);
    for (int k = 0; k < 4; k++) chk("a5_preamble", sym_at(k), 8'hBC);
    chk("a5_sym", sym_at(4), 8'hA5);
    chk("a5_after", sym_at(5), 8'hBC);

    send(8'h01, 1'b1, w);
    send(8'h02, 1'b1, w2);
    send(8'h03, 1'b1, w3);
    chk("stream_wait2", w2, 7);
    chk("stream_wait3", w3, 7);
    run_to(82);
    chk("stream_s1", sym_at(7), 8'h01);
    chk("stream_s2", sym_at(8), 8'h02);
    chk("stream_s3", sym_at(9), 8'h03);

    run_to(88);
    send(8'h3C, 1'b1, w);
    chk("edge_wait", w, 0);
    chk("edge_ready_lo", ready_out, 0);
    run_to(105);
    chk("edge_comma", sym_at(11), 8'hBC);
    chk("edge_byte", sym_at(12), 8'h3C);

    nd = ndata;
    send(8'hBC, 1'b0, w);
    run_to(121);
    chk("bc_verbatim", sym_at(14), 8'hBC);
    chk("bc_no_data", ndata, nd);

    run_to(122);
    send(8'hF0, 1'b1, w);
    run_to(129);
    chk("f0_bit7", data_out, 1);
    chk("f0_start", sym_start, 1);
    run_to(133);
    reset = 1'b0;
    #1;
    chk("midrst_data", data_out, 0);
    chk("midrst_ready", ready_out, 0);
    chk("midrst_active", active_out, 0);
    repeat (2) tick();
    rel();
    preamble_only("rerun");
    chk("exp_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/paralelo_serial.md
Name: paralelo_serial

Overview:
- Transmit-side serializer of the PCIe physical-layer lane; sits directly upstream of serial_paralelo and drives its data_paralelo_serial input.
- Accepts bytes through a valid/ready handshake into a 1-deep holding register and shifts them out MSB-first, one bit per clk_32f cycle.
- Sends a comma (8'hBC) preamble after reset so the receiver can lock.
- Fills every idle symbol slot with a comma.

Parameters:
- SYNC_SYMBOLS, 4, number of comma symbols sent after reset before data may go out (legal range 1..15).
- COMMA, 8'hBC, idle/sync symbol value.

Ports:
- clk_32f  input  1  bit clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  8  byte to transmit.
- valid_in  input  1  data_in is valid this cycle.
- ready_out  output  1  block can accept data_in this cycle.
- data_out  output  1  serial line to serial_paralelo.
- active_out  output  1  preamble complete; data symbols may go out.
- sym_start  output  1  data_out currently carries bit 7 of a symbol.

Behaviour:
- One clock, clk_32f. Reset is asynchronous and active-low; all state clears immediately while reset==0.
- Reset values:
  - shreg=0, data_out=0
  - bit_cnt=7
  - state=SYNC, sync_cnt=0
  - hold_full=0, hold=0
  - active_out=0, sym_start=0
  - ready_out=0
- data_out = shreg[7] (registered). sym_start = (bit_cnt==0), registered alongside.
- Symbol boundary: the edge where bit_cnt==7.
  - At this edge: shreg <= next symbol, bit_cnt <= 0.
  - At every other edge: shreg <= shreg<<1, bit_cnt <= bit_cnt+1.
  - A symbol therefore occupies exactly 8 cycles.
- FSM states: SYNC, RUN.
  - SYNC: at each boundary, load COMMA and increment sync_cnt. On the boundary that loads comma number SYNC_SYMBOLS, move to RUN.
  - RUN: at each boundary, if hold_full, load hold and clear hold_full; otherwise load COMMA.
  - No return to SYNC except through reset.
  - active_out is set on the first boundary edge executed in RUN, i.e. the edge that loads the first post-preamble symbol, whether data or comma.
- Handshake:
  - ready_out = ~hold_full, gated to 0 while in reset and on the cycle reset is released. It goes high from the first edge after release.
  - A transfer occurs at an edge with valid_in && ready_out: hold <= data_in, hold_full <= 1.
  - Bytes may be accepted during SYNC. They wait in hold until the first RUN boundary.
  - No bypass: if the transfer edge is also a boundary, the byte stays in hold. It goes out at the next boundary; the current boundary sends COMMA, or the previous hold contents if hold was full.
  - With hold full and valid_in high, ready_out=0 and data_in is ignored. The upstream must hold valid_in and data_in stable.
- Sustained throughput: 1 byte per 8 cycles. The boundary clears hold_full, and a new byte is accepted on the following edge.
- A data byte equal to COMMA is transmitted verbatim. The receiver treats it as idle; upstream must avoid sending it.
- Reset asserted mid-symbol or mid-handshake: the partial symbol is discarded and hold is lost. After release, the full preamble repeats.

Decomposition:
- Shared package pci_phy_pkg holds COMMA (8'hBC), the SYNC/RUN state encoding, and the symbol width constant 8.
- No sub-module is needed. The 1-deep holding register is simple enough to stay inline.

Test Plan:
- Release reset with valid_in=0, observe 64 cycles:
  - data_out carries 8 consecutive 8'hBC symbols (1,0,1,1,1,1,0,0 each), sym_start high every 8th cycle.
  - active_out rises on the 5th boundary.
  - ready_out=1 from the first edge after release.
- Assert 8'hA5 with valid_in for one cycle during SYNC:
  - ready_out drops; 4 commas go out first.
  - The 5th symbol is 1,0,1,0,0,1,0,1.
  - Commas follow; ready_out returns high after that boundary.
- Stream 8'h01, 8'h02, 8'h03 back-to-back, holding valid_in until each is accepted:
  - Symbols 01, 02, 03 go out contiguously with no comma between them.
  - ready_out is low for 7 of every 8 cycles.
- Present a byte on the exact boundary edge while hold is empty:
  - A comma goes out that symbol; the byte goes out in the next symbol.
- Pull reset low at bit 3 of data symbol 8'hF0:
  - data_out=0, ready_out=0, active_out=0 immediately.
  - After release, the full 4-comma preamble restarts and 8'hF0 is never sent.
- Send data 8'hBC:
  - It is emitted verbatim, indistinguishable from a comma; the bench receiver model flags no valid byte.
